taus_stream_checker: RTL

//  Consumer-side checker for the dual Tausworthe (taus88) URNG streams oTaus1/oTaus2.

---
 rtl/taus_pkg.sv | 27 ++
 rtl/taus88_step.sv | 26 ++
 rtl/taus_stream_checker.sv | 109 ++++++++++
 3 files changed

// File: rtl/taus_pkg.sv
// Shared taus88 constants and checker state type.
// Used by the step function and the stream checker top.
package taus_pkg;

  localparam int TAUS_W = 32;

  localparam int S1_SHL_A = 13;
  localparam int S1_SHR   = 19;
  localparam int S1_SHL_B = 12;
  localparam int S2_SHL_A = 2;
  localparam int S2_SHR   = 25;
  localparam int S2_SHL_B = 4;
  localparam int S3_SHL_A = 3;
  localparam int S3_SHR   = 11;
  localparam int S3_SHL_B = 17;

  localparam logic [TAUS_W-1:0] S1_MASK = 32'hFFFFFFFE;
  localparam logic [TAUS_W-1:0] S2_MASK = 32'hFFFFFFF8;
  localparam logic [TAUS_W-1:0] S3_MASK = 32'hFFFFFFF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage

// File: rtl/taus88_step.sv
// One combinational taus88 step: three component states in, advanced states and sample out.
module taus88_step
  import taus_pkg::*;
(
  input  logic [TAUS_W-1:0] iS1,
  input  logic [TAUS_W-1:0] iS2,
  input  logic [TAUS_W-1:0] iS3,
  output logic [TAUS_W-1:0] oS1,
  output logic [TAUS_W-1:0] oS2,
  output logic [TAUS_W-1:0] oS3,
  output logic [TAUS_W-1:0] oSample
);

  logic [TAUS_W-1:0] t1, t2, t3;

  always_comb begin
    t1  = ((iS1 << S1_SHL_A) ^ iS1) >> S1_SHR;
    t2  = ((iS2 << S2_SHL_A) ^ iS2) >> S2_SHR;
    t3  = ((iS3 << S3_SHL_A) ^ iS3) >> S3_SHR;
    oS1 = ((iS1 & S1_MASK) << S1_SHL_B) ^ t1;
    oS2 = ((iS2 & S2_MASK) << S2_SHL_B) ^ t2;
    oS3 = ((iS3 & S3_MASK) << S3_SHL_B) ^ t3;
    oSample = oS1 ^ oS2 ^ oS3;
  end

endmodule

// File: rtl/taus_stream_checker.sv
// Regenerates both taus88 streams from the seeds and checks each valid sample.
// Reports pass/fail, a saturating error count and the first failing sample index.
module taus_stream_checker
  import taus_pkg::*;
#(
  parameter int N     = 10000,
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [31:0]       iUrng_seed1,
  input  logic [31:0]       iUrng_seed2,
  input  logic [31:0]       iUrng_seed3,
  input  logic [31:0]       iUrng_seed4,
  input  logic [31:0]       iUrng_seed5,
  input  logic [31:0]       iUrng_seed6,
  input  logic              iValid,
  input  logic [31:0]       iTaus1,
  input  logic [31:0]       iTaus2,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic [ERR_W-1:0]  oErrCnt,
  output logic [CNT_W-1:0]  oSampleCnt,
  output logic [CNT_W-1:0]  oFirstErrIdx
);

  // state | meaning
  // IDLE  | no run since reset; waiting for iStart
  // RUN   | comparing valid samples against the regenerated streams
  // DONE  | N samples compared; results held until the next iStart

  stateT state, stateNext;

  logic [TAUS_W-1:0] shA1, shA2, shA3, shB1, shB2, shB3;
  logic [TAUS_W-1:0] nxA1, nxA2, nxA3, nxB1, nxB2, nxB3;
  logic [TAUS_W-1:0] expA, expB;

  logic             startOk, accept, mismatch, lastAccept;
  logic [ERR_W-1:0] errNext;
  logic             passQ;

  taus88_step uStepA (
    .iS1(shA1), .iS2(shA2), .iS3(shA3),
    .oS1(nxA1), .oS2(nxA2), .oS3(nxA3),
    .oSample(expA)
  );

  taus88_step uStepB (
    .iS1(shB1), .iS2(shB2), .iS3(shB3),
    .oS1(nxB1), .oS2(nxB2), .oS3(nxB3),
    .oSample(expB)
  );

  // A start is only honoured outside RUN, so it can never collide with an accepted sample.
  assign startOk    = iStart && (state != RUN);
  assign accept     = (state == RUN) && iValid;
  assign mismatch   = accept && ((iTaus1 != expA) || (iTaus2 != expB));
  assign lastAccept = accept && (oSampleCnt == CNT_W'(N - 1));
  assign errNext    = (mismatch && (oErrCnt != {ERR_W{1'b1}})) ? oErrCnt + ERR_W'(1) : oErrCnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart) stateNext = RUN;
      RUN:     if (lastAccept) stateNext = DONE;
      DONE:    if (iStart) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shA1 <= '0; shA2 <= '0; shA3 <= '0;
      shB1 <= '0; shB2 <= '0; shB3 <= '0;
      oErrCnt      <= '0;
      oSampleCnt   <= '0;
      oFirstErrIdx <= '1;
      passQ        <= 1'b0;
    end else if (startOk) begin
      shA1 <= iUrng_seed1; shA2 <= iUrng_seed2; shA3 <= iUrng_seed3;
      shB1 <= iUrng_seed4; shB2 <= iUrng_seed5; shB3 <= iUrng_seed6;
      oErrCnt      <= '0;
      oSampleCnt   <= '0;
      oFirstErrIdx <= '1;
      passQ        <= 1'b0;
    end else if (accept) begin
      shA1 <= nxA1; shA2 <= nxA2; shA3 <= nxA3;
      shB1 <= nxB1; shB2 <= nxB2; shB3 <= nxB3;
      oSampleCnt <= oSampleCnt + CNT_W'(1);
      oErrCnt    <= errNext;
      // A zero error count means no mismatch has been seen yet this run.
      if (mismatch && (oErrCnt == '0)) oFirstErrIdx <= oSampleCnt;
      if (lastAccept) passQ <= (errNext == '0);
    end
  end

  assign oBusy = (state == RUN);
  assign oDone = (state == DONE);
  assign oPass = passQ;

endmodule
